imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the program counter logic and the 64-word instruction memory. It drives the word-aligned imem address, captures each returned word together with its PC into a small prefetch FIFO, and hands instructions to decode over a valid/ready handshake. It also handles control-flow redirects and halts fetch on misaligned or out-of-range addresses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/imem_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default constants for the instruction fetch sequencer
package fetch_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam int          MEM_WORDS_DEF = 64;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding {pc, instr} pairs; flush beats push
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fifo_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wdata,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch sequencer: pc, RUN/HALT control, redirects, prefetch FIFO
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              MEM_WORDS = MEM_WORDS_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              DEPTH     = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic            in_range;
  entry_t          wdata;
  entry_t          head;

  assign in_range  = (pc_q[XLEN-1:2] < (XLEN-2)'(MEM_WORDS));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign imem_addr = pc_q;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign wdata     = '{pc: pc_q, instr: imem_rd};
  // HALT with nothing left to drain is a fault; a misaligned redirect also
  // lands here because its flush leaves the FIFO empty.
  assign fault     = (state_q == HALT) && empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] == 2'b00) ? RUN : HALT;
    end else if (state_q == RUN) begin
      if (!in_range) begin
        state_d = HALT;
      end else if (!full || pop) begin
        push = 1'b1;
        pc_d = pc_q + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed bench with queue-based fetch model
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;
  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] imem [MEM_WORDS];

  always #5 clk = ~clk;

  assign imem_rd = imem[imem_addr[7:2]];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;
  bit          mhalt;
  bit          mmis;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    mpc       = 32'h0;
    mhalt     = 1'b0;
    mmis      = 1'b0;
    m_fetched = 32'h0;
    m_stall   = 32'h0;
  endfunction

  // Compare current outputs with the model, then advance the model by one clock.
  task automatic tick();
    bit pop;
    chk("imem_addr", imem_addr, mpc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("fault", {31'b0, fault}, {31'b0, mmis || (mhalt && mq.size() == 0)});
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
    if (mq.size() > 0 && !out_ready) m_stall++;
`endif
    pop = (mq.size() > 0) && out_ready;
    if (out_valid && out_ready) begin
      got_pc.push_back(out_pc);
      got_instr.push_back(out_instr);
    end
    if (redirect_valid) begin
      mq.delete();
      mpc   = redirect_pc;
      mmis  = (redirect_pc[1:0] != 2'b00);
      mhalt = mmis;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!mhalt) begin
        if ((mpc >> 2) >= MEM_WORDS) begin
          mhalt = 1'b1;
        end else if (mq.size() < DEPTH) begin
          mq.push_back('{pc: mpc, instr: mpc >> 2});
          mpc = mpc + 32'd4;
          m_fetched++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_stall", perf_stall, 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    got_pc.delete();
    got_instr.delete();
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) imem[i] = i;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    do_reset();

    // Streaming from reset: pc 0,4,8,... one per cycle, instr = word index
    ticks(6);
    chk("t1_count", got_pc.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
      chk("t1_pc", got_pc[i], 32'(i * 4));
      chk("t1_instr", got_instr[i], 32'(i));
    end

    // Backpressure: FIFO fills, address holds at 8, head holds pc 0
    do_reset();
    out_ready = 1'b0;
    ticks(6);
    chk("t2_addr_hold", imem_addr, 32'h8);
    chk("t2_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    ticks(5);
    chk("t2_count", got_pc.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_pc.size(); i++) chk("t2_pc", got_pc[i], 32'(i * 4));

    // Redirect while full: bubble, then target; nothing stale
    out_ready = 1'b0;
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bubble", {31'b0, out_valid}, 32'h0);
    got_pc.delete();
    out_ready = 1'b1;
    ticks(3);
    chk("t3_count", got_pc.size(), 32'd2);
    if (got_pc.size() == 2) begin
      chk("t3_first", got_pc[0], 32'h40);
      chk("t3_second", got_pc[1], 32'h44);
    end

    // Misaligned redirect faults; aligned redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    chk("t4_fault_set", {31'b0, fault}, 32'h1);
    ticks(3);
    chk("t4_still_idle", {31'b0, out_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("t4_fault_clr", {31'b0, fault}, 32'h0);
    tick();
    chk("t4_target", out_pc, 32'h10);

    // Redirect coinciding with a pop still delivers the popped head
    got_pc.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hF0;
    tick();
    redirect_valid = 1'b0;
    chk("t5_pop_on_redirect", got_pc.size(), 32'd1);

    // Run off the end of imem: 0xFC delivered, then fault with address at 0x100
    got_pc.delete();
    for (int i = 0; i < 10; i++) begin
      out_ready = (i != 3);
      tick();
    end
    chk("t5_last_pc", got_pc.size() > 0 ? got_pc[got_pc.size()-1] : 32'hDEAD, 32'hFC);
    chk("t5_fault", {31'b0, fault}, 32'h1);
    chk("t5_addr", imem_addr, 32'h100);
    chk("t5_idle", {31'b0, out_valid}, 32'h0);

    // Mixed readiness with 3 stall cycles, then reset mid-run
    do_reset();
    for (int i = 0; i < 12; i++) begin
      out_ready = !(i == 2 || i == 5 || i == 6);
      tick();
    end
    do_reset();
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
